onchip_mem_rr_arbiter: RTL and testbench
========================================

// Module: onchip_mem_rr_arbiter
// PURPOSE
//  Shares the single-port 32-bit on-chip RAM (25000 words, 1-cycle read latency) between N_REQ Avalon-MM requesters.
//  Round-robin arbitration with a bounded hold (back-to-back grant) count.
//  Pipelined reads: one issue per cycle; data returned with readdatavalid one cycle after issue.
//  Sits between the CPU data master, the DMA and the RAM slave port.
// PARAMETERS
//  N_REQ      2      number of requesters (2..4)
//  ADDR_W     15     word address width
//  NUMWORDS   25000  implemented depth; addresses >= NUMWORDS are out of range
//  MAX_HOLD   4      max consecutive grants to one requester while another is waiting (>=1)
// PORTS
//  clk             in   1             clock; all logic on rising edge
//  reset           in   1             synchronous, active-high
//  req_address     in   N_REQ*ADDR_W  per-requester word address, slice i = requester i
//  req_byteenable  in   N_REQ*4       per-requester byte enables
//  req_read        in   N_REQ         read request
//  req_write       in   N_REQ         write request (read and write both high = write wins)
//  req_writedata   in   N_REQ*32      write data
//  req_waitrequest out  N_REQ         high = request not accepted this cycle
//  req_readdata    out  N_REQ*32      read data, valid with req_readdatavalid
//  req_readdatavalid out N_REQ        one-cycle pulse per accepted read
//  mem_address     out  ADDR_W        to RAM address
//  mem_byteenable  out  4             to RAM byteenable
//  mem_chipselect  out  1             to RAM chipselect
//  mem_write       out  1             to RAM write
//  mem_writedata   out  32            to RAM writedata
//  mem_clken       out  1             to RAM clken; held 1 (not toggled by this block)
//  mem_readdata    in   32            from RAM; valid the cycle after address issue
//  oor_error       out  1             sticky: an out-of-range access was accepted
// BEHAVIOUR
//  Reset values: req_waitrequest all 1, req_readdatavalid 0, req_readdata 0, mem_chipselect 0,
//   mem_write 0, oor_error 0, rr pointer = 0, hold_cnt = 0, rd_pending = 0.
//  Arbitration (combinational from registered state): requester i is active if req_read[i]|req_write[i].
//   If the current owner is active and (hold_cnt < MAX_HOLD-1 or no other requester is active) -> owner keeps grant.
//   Otherwise grant goes to the first active requester searching from owner+1 modulo N_REQ. No active requester -> no grant.
//  Granted requester: req_waitrequest[g]=0 in the same cycle; all others 1. mem_* driven from slice g.
//  hold_cnt: increments on a grant to the same owner; resets to 0 on an owner change or on an idle cycle;
//   saturates at MAX_HOLD-1.
//  Write: accepted in cycle t; RAM written on the edge ending t; no response.
//  Read: accepted in cycle t; registered rd_pending=1, rd_owner=g at end of t; in t+1 req_readdatavalid[rd_owner]=1,
//   req_readdata slice = mem_readdata (registered copy is not required; pass-through with valid gating).
//   Back-to-back reads from any mix of requesters: one readdatavalid per cycle, in issue order.
//  Out of range (address >= NUMWORDS): accepted normally, mem_chipselect=0 (no RAM access);
//   read returns 32'h0000_0000 with readdatavalid at t+1; oor_error set, cleared only by reset.
//  Read-during-write to the same address across cycles: write at t, read at t+1 returns new data.
//  Reset mid-operation: a read issued in the cycle before reset produces no readdatavalid;
//   all state returns to reset values on the next edge.
//  Owner index width = $clog2(N_REQ); pointer wraps N_REQ-1 -> 0.
// STRUCTURE
//  Shared package onchip_mem_pkg: RAM_WORDS=25000, RAM_ADDR_W=15, RAM_DATA_W=32, RAM_BE_W=4,
//   OOR_READ_VALUE=32'h0.
//  One sub-module: rr_grant_sel (pure combinational round-robin select with hold: inputs active, owner,
//   hold_exceeded; output grant_onehot, grant_idx, grant_valid). Pipeline/hold/error logic in the top.
// TESTING
//  Single read: req0 reads addr 0x0010 (pre-loaded 32'hCAFE_0001) -> waitrequest[0]=0 at t,
//   readdatavalid[0]=1 with 32'hCAFE_0001 at t+1.
//  Byte write then read: req1 writes 32'h1122_3344 be=4'b0101 to 0x0020 (was 0) -> read returns 32'h0022_0044.
//  Contention, MAX_HOLD=4: req0 and req1 read continuously from reset -> grants 0,0,0,0,1,1,1,1,0...;
//   readdatavalid owner sequence matches, delayed by one cycle.
//  Out of range: req0 reads 15'd25000 -> mem_chipselect=0, readdata 0 at t+1, oor_error=1 until reset.
//  Write then read same address: req0 write 32'hA5A5_A5A5 to 0x0100 at t, req1 read 0x0100 at t+1 -> 32'hA5A5_A5A5.
//  Reset mid-read: read accepted at t, reset high at t+1 -> no readdatavalid, all waitrequest=1 after the edge.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_pkg
//   Shared constants for the on-chip RAM and the blocks that front it.
//   RAM_WORDS       implemented depth of the RAM in 32-bit words
//   RAM_ADDR_W      word address width presented to the RAM slave port
//   RAM_DATA_W      data width of the RAM
//   RAM_BE_W        byte-enable width (one bit per byte lane)
//   OOR_READ_VALUE  value returned for a read that falls outside the RAM
//   idx_width()     width of an index able to hold 0..n-1 (minimum 1 bit)
// ---------------------------------------------------------------------------
package onchip_mem_pkg;

   localparam int RAM_WORDS  = 25000;
   localparam int RAM_ADDR_W = 15;
   localparam int RAM_DATA_W = 32;
   localparam int RAM_BE_W   = 4;

   localparam logic [RAM_DATA_W-1:0] OOR_READ_VALUE = 32'h0000_0000;

   // $clog2(1) is 0, which cannot size a vector; clamp to one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/onchip_mem_rr_arbiter_grant_sel.sv
// ---------------------------------------------------------------------------
// rr_grant_sel
//   Purely combinational round-robin selector with a hold option.
//   The current owner keeps the grant while it is still requesting, unless it
//   has used up its hold allowance and someone else is waiting. Otherwise the
//   search starts at owner+1 and wraps, so the owner itself is the last
//   candidate considered.
// Ports
//   active         in  N_REQ   per-requester request present
//   owner          in  IDX_W   requester that held the last grant
//   hold_exceeded  in  1       owner has reached its back-to-back limit
//   grant_onehot   out N_REQ   one-hot grant (all zero when grant_valid=0)
//   grant_idx      out IDX_W   index of the granted requester
//   grant_valid    out 1       a grant was issued this cycle
// ---------------------------------------------------------------------------
module rr_grant_sel
   import onchip_mem_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] active,
   input  logic [IDX_W-1:0] owner,
   input  logic             hold_exceeded,
   output logic [N_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [N_REQ-1:0] owner_onehot;
   logic             owner_active;
   logic             others_active;

   // Mask-based tests avoid indexing active[] with an owner value that is
   // outside 0..N_REQ-1 when N_REQ is not a power of two.
   assign owner_onehot  = N_REQ'(1) << owner;
   assign owner_active  = |(active & owner_onehot);
   assign others_active = |(active & ~owner_onehot);

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_valid  = 1'b0;

      if (owner_active && (!hold_exceeded || !others_active)) begin
         grant_valid = 1'b1;
         grant_idx   = owner;
      end else begin
         for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_valid && active[IDX_W'((int'(owner) + k) % N_REQ)]) begin
               grant_valid = 1'b1;
               grant_idx   = IDX_W'((int'(owner) + k) % N_REQ);
            end
         end
      end

      if (grant_valid) begin
         grant_onehot = N_REQ'(1) << grant_idx;
      end
   end

endmodule

// File: rtl/onchip_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_rr_arbiter
//   Shares one single-port on-chip RAM between N_REQ Avalon-MM requesters
//   (CPU data master, DMA, ...). Round-robin arbitration with a bounded number
//   of back-to-back grants to one requester while others wait. Reads are
//   pipelined: one issue per cycle, readdatavalid exactly one cycle later to
//   the requester that issued it. Accesses beyond NUMWORDS are accepted but do
//   not touch the RAM; reads return OOR_READ_VALUE and raise sticky oor_error.
// Ports
//   clk, reset          clock and synchronous active-high reset
//   req_address         N_REQ*ADDR_W  word address, slice i = requester i
//   req_byteenable      N_REQ*4       byte enables
//   req_read/req_write  N_REQ         requests (write wins when both high)
//   req_writedata       N_REQ*32      write data
//   req_waitrequest     N_REQ         low only for the requester granted now
//   req_readdata        N_REQ*32      read data, qualified by readdatavalid
//   req_readdatavalid   N_REQ         one pulse per accepted read
//   mem_*               RAM slave port (address, byteenable, chipselect,
//                       write, writedata, clken, readdata)
//   oor_error           sticky out-of-range flag, cleared only by reset
// ---------------------------------------------------------------------------
module onchip_mem_rr_arbiter
   import onchip_mem_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int ADDR_W   = RAM_ADDR_W,
   parameter int NUMWORDS = RAM_WORDS,
   parameter int MAX_HOLD = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ*ADDR_W-1:0]      req_address,
   input  logic [N_REQ*RAM_BE_W-1:0]    req_byteenable,
   input  logic [N_REQ-1:0]             req_read,
   input  logic [N_REQ-1:0]             req_write,
   input  logic [N_REQ*RAM_DATA_W-1:0]  req_writedata,
   output logic [N_REQ-1:0]             req_waitrequest,
   output logic [N_REQ*RAM_DATA_W-1:0]  req_readdata,
   output logic [N_REQ-1:0]             req_readdatavalid,
   output logic [ADDR_W-1:0]            mem_address,
   output logic [RAM_BE_W-1:0]          mem_byteenable,
   output logic                         mem_chipselect,
   output logic                         mem_write,
   output logic [RAM_DATA_W-1:0]        mem_writedata,
   output logic                         mem_clken,
   input  logic [RAM_DATA_W-1:0]        mem_readdata,
   output logic                         oor_error
);

   localparam int IDX_W  = idx_width(N_REQ);
   localparam int HOLD_W = idx_width(MAX_HOLD);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   // One extra bit so a depth of exactly 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(NUMWORDS);

   // ------------------------------------------------------------------
   // Per-requester views of the flattened request buses
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0]     addr_arr [N_REQ];
   logic [RAM_BE_W-1:0]   be_arr   [N_REQ];
   logic [RAM_DATA_W-1:0] wd_arr   [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_address[gi*ADDR_W +: ADDR_W];
      assign be_arr[gi]   = req_byteenable[gi*RAM_BE_W +: RAM_BE_W];
      assign wd_arr[gi]   = req_writedata[gi*RAM_DATA_W +: RAM_DATA_W];
   end

   // ------------------------------------------------------------------
   // Registered arbitration and read-pipeline state
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]  owner_reg,    owner_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic              granted_reg,  granted_next;   // a grant was issued last cycle
   logic              rd_pending_reg, rd_pending_next;
   logic [IDX_W-1:0]  rd_owner_reg,   rd_owner_next;
   logic              rd_oor_reg,     rd_oor_next;
   logic              oor_error_reg,  oor_error_next;

   // ------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------
   logic [N_REQ-1:0] active;
   logic             hold_exceeded;
   logic [N_REQ-1:0] sel_onehot;
   logic [IDX_W-1:0] grant_idx;
   logic             sel_valid;
   logic             grant_valid;

   assign active        = req_read | req_write;
   assign hold_exceeded = (hold_cnt_reg >= HOLD_LAST);

   rr_grant_sel #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_grant_sel (
      .active        (active),
      .owner         (owner_reg),
      .hold_exceeded (hold_exceeded),
      .grant_onehot  (sel_onehot),
      .grant_idx     (grant_idx),
      .grant_valid   (sel_valid)
   );

   // Nothing may be accepted while reset is asserted: an access taken in that
   // cycle would be lost when the state clears on the same edge.
   assign grant_valid     = sel_valid & ~reset;
   assign req_waitrequest = ~(sel_onehot & {N_REQ{grant_valid}});

   // ------------------------------------------------------------------
   // RAM port, driven from the granted slice
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] g_addr;
   logic              g_write;
   logic              g_read;
   logic              in_range;

   assign g_addr   = addr_arr[grant_idx];
   assign g_write  = req_write[grant_idx];
   assign g_read   = req_read[grant_idx] & ~g_write;
   assign in_range = ({1'b0, g_addr} < DEPTH);

   assign mem_address    = g_addr;
   assign mem_byteenable = be_arr[grant_idx];
   assign mem_writedata  = wd_arr[grant_idx];
   assign mem_chipselect = grant_valid & in_range;
   assign mem_write      = grant_valid & in_range & g_write;
   assign mem_clken      = 1'b1;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      owner_next      = owner_reg;
      hold_cnt_next   = '0;
      granted_next    = grant_valid;
      rd_pending_next = grant_valid & g_read;
      rd_owner_next   = rd_owner_reg;
      rd_oor_next     = 1'b0;
      oor_error_next  = oor_error_reg;

      if (grant_valid) begin
         owner_next    = grant_idx;
         rd_owner_next = grant_idx;
         rd_oor_next   = ~in_range;
         if (~in_range) begin
            oor_error_next = 1'b1;
         end
         // Only an unbroken run of grants to the same owner counts towards the
         // hold limit; the first grant after an idle cycle or a handover
         // starts the count again from zero.
         if (granted_reg && (grant_idx == owner_reg)) begin
            hold_cnt_next = (hold_cnt_reg < HOLD_LAST) ? hold_cnt_reg + 1'b1
                                                        : hold_cnt_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_reg      <= '0;
         hold_cnt_reg   <= '0;
         granted_reg    <= 1'b0;
         rd_pending_reg <= 1'b0;
         rd_owner_reg   <= '0;
         rd_oor_reg     <= 1'b0;
         oor_error_reg  <= 1'b0;
      end else begin
         owner_reg      <= owner_next;
         hold_cnt_reg   <= hold_cnt_next;
         granted_reg    <= granted_next;
         rd_pending_reg <= rd_pending_next;
         rd_owner_reg   <= rd_owner_next;
         rd_oor_reg     <= rd_oor_next;
         oor_error_reg  <= oor_error_next;
      end
   end

   assign oor_error = oor_error_reg;

   // ------------------------------------------------------------------
   // Read return: RAM data passes straight through, gated to the issuer.
   // An out-of-range read never reached the RAM, so its stale output is
   // replaced by the fixed value.
   // ------------------------------------------------------------------
   logic [RAM_DATA_W-1:0] rd_data;

   assign rd_data = rd_oor_reg ? OOR_READ_VALUE : mem_readdata;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rd_return
      assign req_readdatavalid[gi] = rd_pending_reg & ~reset &
                                     (rd_owner_reg == IDX_W'(gi));
      assign req_readdata[gi*RAM_DATA_W +: RAM_DATA_W] =
         req_readdatavalid[gi] ? rd_data : '0;
   end

endmodule

// File: tb/tb_onchip_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_rr_arbiter
//   Two requesters in front of a behavioural 25000-word RAM. Stimulus issues
//   directed accesses and pushes each expected read response (owner, data,
//   cycle) into a queue; an independent monitor pops and compares whenever a
//   readdatavalid appears.
// ---------------------------------------------------------------------------
module tb_onchip_mem_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 15;
   localparam int NW = 25000;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*AW-1:0] req_address;
   logic [N*4-1:0]  req_byteenable;
   logic [N-1:0]    req_read;
   logic [N-1:0]    req_write;
   logic [N*32-1:0] req_writedata;
   logic [N-1:0]    req_waitrequest;
   logic [N*32-1:0] req_readdata;
   logic [N-1:0]    req_readdatavalid;
   logic [AW-1:0]   mem_address;
   logic [3:0]      mem_byteenable;
   logic            mem_chipselect;
   logic            mem_write;
   logic [31:0]     mem_writedata;
   logic            mem_clken;
   logic [31:0]     mem_readdata;
   logic            oor_error;

   always #5 clk = ~clk;

   onchip_mem_rr_arbiter #(
      .N_REQ    (N),
      .ADDR_W   (AW),
      .NUMWORDS (NW),
      .MAX_HOLD (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_address       (req_address),
      .req_byteenable    (req_byteenable),
      .req_read          (req_read),
      .req_write         (req_write),
      .req_writedata     (req_writedata),
      .req_waitrequest   (req_waitrequest),
      .req_readdata      (req_readdata),
      .req_readdatavalid (req_readdatavalid),
      .mem_address       (mem_address),
      .mem_byteenable    (mem_byteenable),
      .mem_chipselect    (mem_chipselect),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_clken         (mem_clken),
      .mem_readdata      (mem_readdata),
      .oor_error         (oor_error)
   );

   // Behavioural RAM: byte-lane writes, registered read (1-cycle latency).
   logic [31:0] ram [0:NW-1];

   initial begin
      for (int i = 0; i < NW; i++) ram[i] = 32'h0;
      ram[16'h0010] = 32'hCAFE_0001;
      mem_readdata  = 32'h0;
   end

   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Scoreboard and monitor
   // ------------------------------------------------------------------
   typedef struct {
      int          owner;
      logic [31:0] data;
      int          at_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   mon_owner;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].at_cyc < cyc) begin
         check("rdv_missing_at_cycle", cyc, sb[0].at_cyc);
         void'(sb.pop_front());
      end
      if (req_readdatavalid != '0) begin
         if ($countones(req_readdatavalid) != 1)
            check("rdv_onehot", req_readdatavalid, 2'b01);
         mon_owner = req_readdatavalid[1] ? 1 : 0;
         if (sb.size() == 0) begin
            check("rdv_unexpected", req_readdatavalid, 0);
         end else begin
            mon_e = sb.pop_front();
            $display("read return: owner=%0d data=%h cycle=%0d", mon_owner,
                     req_readdata[mon_owner*32 +: 32], cyc);
            check("rdv_owner", mon_owner, mon_e.owner);
            check("rdv_cycle", cyc, mon_e.at_cyc);
            check("rdv_data", req_readdata[mon_owner*32 +: 32], mon_e.data);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------
   task automatic clear_reqs();
      req_address    = '0;
      req_byteenable = '0;
      req_read       = '0;
      req_write      = '0;
      req_writedata  = '0;
   endtask

   task automatic drive(input int who, input bit rd, input bit wr, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      req_address[who*AW +: AW]  = addr;
      req_byteenable[who*4 +: 4] = be;
      req_read[who]              = rd;
      req_write[who]             = wr;
      req_writedata[who*32 +: 32] = wd;
   endtask

   task automatic issue(input string name, input int who, input bit rd, input bit wr,
                        input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd,
                        input logic [1:0] exp_wait, input bit exp_cs,
                        input bit expect_rdv, input logic [31:0] exp_data);
      @(posedge clk); #1;
      clear_reqs();
      drive(who, rd, wr, addr, be, wd);
      @(negedge clk);
      $display("issue %s: req%0d rd=%0b wr=%0b addr=%h wait=%b cs=%b", name, who, rd, wr,
               addr, req_waitrequest, mem_chipselect);
      check({name, "_waitrequest"}, req_waitrequest, exp_wait);
      check({name, "_chipselect"}, mem_chipselect, exp_cs);
      check({name, "_mem_write"}, mem_write, wr & exp_cs);
      if (expect_rdv) sb.push_back('{who, exp_data, cyc + 1});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         clear_reqs();
      end
   endtask

   // Expected grant sequence for two continuous readers from reset.
   int grant_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

   initial begin
      reset = 1'b1;
      clear_reqs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_waitrequest", req_waitrequest, 2'b11);
      check("rst_readdatavalid", req_readdatavalid, 2'b00);
      check("rst_readdata", req_readdata, 64'h0);
      check("rst_chipselect", mem_chipselect, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_oor_error", oor_error, 1'b0);
      check("rst_clken", mem_clken, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single read, byte-masked write + readback, write-wins, write->read.
      issue("rd0", 0, 1, 0, 15'h0010, 4'hF, 32'h0, 2'b10, 1, 1, 32'hCAFE_0001);
      issue("wr1_be", 1, 0, 1, 15'h0020, 4'b0101, 32'h1122_3344, 2'b01, 1, 0, 32'h0);
      issue("rd1_be", 1, 1, 0, 15'h0020, 4'hF, 32'h0, 2'b01, 1, 1, 32'h0022_0044);
      issue("rdwr0", 0, 1, 1, 15'h0030, 4'hF, 32'hDEAD_BEEF, 2'b10, 1, 0, 32'h0);
      issue("rd0_ww", 0, 1, 0, 15'h0030, 4'hF, 32'h0, 2'b10, 1, 1, 32'hDEAD_BEEF);
      issue("wr0_a5", 0, 0, 1, 15'h0100, 4'hF, 32'hA5A5_A5A5, 2'b10, 1, 0, 32'h0);
      issue("rd1_a5", 1, 1, 0, 15'h0100, 4'hF, 32'h0, 2'b01, 1, 1, 32'hA5A5_A5A5);
      idle(2);

      // Address range boundary: last word, then a real read, then first OOR word.
      issue("rd_last", 0, 1, 0, 15'd24999, 4'hF, 32'h0, 2'b10, 1, 1, 32'h0);
      check("oor_before", oor_error, 1'b0);
      issue("rd0_again", 0, 1, 0, 15'h0010, 4'hF, 32'h0, 2'b10, 1, 1, 32'hCAFE_0001);
      issue("rd_oor", 0, 1, 0, 15'd25000, 4'hF, 32'h0, 2'b10, 0, 1, 32'h0);
      idle(1);
      @(negedge clk);
      check("oor_set", oor_error, 1'b1);
      idle(3);
      @(negedge clk);
      check("oor_sticky", oor_error, 1'b1);

      // Reset clears the sticky flag and the arbitration state.
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("oor_cleared", oor_error, 1'b0);

      // Contention from reset: both requesters read continuously.
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            drive(0, 1, 0, 15'h0010, 4'hF, 32'h0);
            drive(1, 1, 0, 15'h0100, 4'hF, 32'h0);
         end
         @(negedge clk);
         $display("contention cycle %0d: wait=%b", c, req_waitrequest);
         check($sformatf("contend_grant%0d", c), req_waitrequest,
               (grant_seq[c] == 0) ? 2'b10 : 2'b01);
         sb.push_back('{grant_seq[c], (grant_seq[c] == 0) ? 32'hCAFE_0001 : 32'hA5A5_A5A5,
                        cyc + 1});
      end
      idle(2);

      // Reset while a read is in flight: its data must never be returned.
      issue("rd_rst", 0, 1, 0, 15'h0010, 4'hF, 32'h0, 2'b10, 1, 0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_rdv", req_readdatavalid, 2'b00);
      check("rstmid_wait", req_waitrequest, 2'b11);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_wait_after", req_waitrequest, 2'b11);
      check("rstmid_cs_after", mem_chipselect, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      clear_reqs();
      idle(3);
      @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
